// File: rtl/tape_punch.sv
// Paper-tape punch model: paces PUNCH_SYNC pulses from the ms tick and records
// each punched 5-bit character into a readback buffer.
module tape_punch #(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned START_MS   = 20,
    parameter int unsigned CHAR_MS    = 59,
    parameter int unsigned SYNC_AT_MS = 10,
    parameter int unsigned SYNC_CLKS  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic                       PUNCH_SIGNAL,
    input  logic [4:0]                 punch_code,
    output logic                       PUNCH_SYNC,
    output logic                       PUNCHED_TAPE1,
    output logic                       PUNCHED_TAPE2,
    output logic                       PUNCHED_TAPE3,
    output logic                       PUNCHED_TAPE4,
    output logic                       PUNCHED_TAPE5,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [4:0]                 rd_data,
    output logic [$clog2(DEPTH):0]     char_count,
    output logic                       overflow,
    input  logic                       clear
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned TMAX = (START_MS > CHAR_MS) ? START_MS : CHAR_MS;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned SW   = $clog2(SYNC_CLKS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SPINUP,
        PERIOD,
        PULSE,
        CAPTURE,
        FINISH
    } state_t;

    state_t          state;
    logic            ps_m, ps_s;
    logic [4:0]      code_m, code_s;
    logic [TW-1:0]   tcnt;
    logic [SW-1:0]   ccnt;
    logic [4:0]      code_cap;
    logic [4:0]      tape;
    logic [4:0]      mem [DEPTH];
    logic            store;

    // Two-flop synchronizers for the G-15 side request and magnet lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_m   <= 1'b0;
            ps_s   <= 1'b0;
            code_m <= 5'd0;
            code_s <= 5'd0;
        end else begin
            ps_m   <= PUNCH_SIGNAL;
            ps_s   <= ps_m;
            code_m <= punch_code;
            code_s <= code_m;
        end
    end

    // The character-period counter keeps running through PULSE/CAPTURE so the
    // spacing between sync edges is exactly CHAR_MS ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tcnt       <= '0;
            ccnt       <= '0;
            code_cap   <= 5'd0;
            PUNCH_SYNC <= 1'b0;
            tape       <= 5'd0;
            char_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (clear) begin
                char_count <= '0;
                overflow   <= 1'b0;
                tape       <= 5'd0;
            end
            case (state)
                IDLE: begin
                    if (ps_s) begin
                        state <= SPINUP;
                        tcnt  <= tick ? TW'(1) : '0;
                    end
                end
                SPINUP: begin
                    if (!ps_s) begin
                        state <= IDLE;
                        tcnt  <= '0;
                    end else if (tick) begin
                        if (tcnt == TW'(START_MS - 1)) begin
                            state <= PERIOD;
                            tcnt  <= '0;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                PERIOD: begin
                    if (tick) begin
                        tcnt <= tcnt + TW'(1);
                        if (tcnt == TW'(SYNC_AT_MS - 1)) begin
                            state      <= PULSE;
                            PUNCH_SYNC <= 1'b1;
                            ccnt       <= '0;
                        end
                    end
                end
                PULSE: begin
                    if (tick) tcnt <= tcnt + TW'(1);
                    if (ccnt == SW'(SYNC_CLKS - 1)) begin
                        PUNCH_SYNC <= 1'b0;
                        code_cap   <= code_s;
                        state      <= CAPTURE;
                    end else begin
                        ccnt <= ccnt + SW'(1);
                    end
                end
                CAPTURE: begin
                    if (tick) tcnt <= tcnt + TW'(1);
                    state <= FINISH;
                    if (!clear) begin
                        tape <= code_cap;
                        if (char_count < CW'(DEPTH)) char_count <= char_count + CW'(1);
                        else                         overflow   <= 1'b1;
                    end
                end
                FINISH: begin
                    if (tick) begin
                        if (tcnt == TW'(CHAR_MS - 1)) begin
                            tcnt  <= '0;
                            state <= ps_s ? PERIOD : IDLE;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign store = (state == CAPTURE) && !clear && (char_count < CW'(DEPTH));

    // Tape buffer is deliberately not reset so the image survives a reset
    always_ff @(posedge clk) begin
        if (store) mem[char_count[AW-1:0]] <= code_cap;
    end

    assign rd_data       = mem[rd_addr];
    assign PUNCHED_TAPE1 = tape[0];
    assign PUNCHED_TAPE2 = tape[1];
    assign PUNCHED_TAPE3 = tape[2];
    assign PUNCHED_TAPE4 = tape[3];
    assign PUNCHED_TAPE5 = tape[4];

endmodule

// File: tb/tb_tape_punch.sv
// Directed bench for tape_punch: timing of sync pulses, buffer capture,
// spin-up abort, buffer-full handling and mid-character reset.
module tb_tape_punch;

    localparam int TP = 10;

    logic        clk = 1'b0;
    logic        rst_n, tick, ps, clear, ps2, clear2;
    logic [4:0]  code, code2;
    logic        sync, t1, t2, t3, t4, t5;
    logic        sync2, u1, u2, u3, u4, u5;
    logic [11:0] rd_addr;
    logic [4:0]  rd_data;
    logic [12:0] count;
    logic        ovf;
    logic [1:0]  rd_addr2;
    logic [4:0]  rd_data2;
    logic [2:0]  count2;
    logic        ovf2;
    logic [4:0]  tape_v, tape2_v;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    assign tape_v  = {t5, t4, t3, t2, t1};
    assign tape2_v = {u5, u4, u3, u2, u1};

    tape_punch dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .PUNCH_SIGNAL(ps), .punch_code(code),
        .PUNCH_SYNC(sync), .PUNCHED_TAPE1(t1), .PUNCHED_TAPE2(t2), .PUNCHED_TAPE3(t3),
        .PUNCHED_TAPE4(t4), .PUNCHED_TAPE5(t5), .rd_addr(rd_addr), .rd_data(rd_data),
        .char_count(count), .overflow(ovf), .clear(clear)
    );

    tape_punch #(.DEPTH(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .tick(tick), .PUNCH_SIGNAL(ps2), .punch_code(code2),
        .PUNCH_SYNC(sync2), .PUNCHED_TAPE1(u1), .PUNCHED_TAPE2(u2), .PUNCHED_TAPE3(u3),
        .PUNCHED_TAPE4(u4), .PUNCHED_TAPE5(u5), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .char_count(count2), .overflow(ovf2), .clear(clear2)
    );

    // Free-running 1-clk tick every TP clocks
    initial begin
        tick = 1'b0;
        forever begin
            repeat (TP - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    int tick_total = 0;
    always @(posedge clk) if (tick) tick_total <= tick_total + 1;

    logic prev_sync = 1'b0, prev_sync2 = 1'b0;
    int   rises = 0, rises2 = 0, hi = 0, width = 0;
    int   rise_tick [64];

    always @(negedge clk) begin
        prev_sync <= sync;
        if (sync && !prev_sync) begin
            rise_tick[rises & 63] <= tick_total;
            rises <= rises + 1;
            hi    <= 1;
        end else if (sync) begin
            hi <= hi + 1;
        end
        if (!sync && prev_sync) width <= hi;
    end

    always @(negedge clk) begin
        prev_sync2 <= sync2;
        if (sync2 && !prev_sync2) rises2 <= rises2 + 1;
    end

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic wait_rises(input bit second, input int target, input int budget);
        int n = 0;
        while (((second ? rises2 : rises) < target) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if ((second ? rises2 : rises) < target) begin
            checks++; fails++;
            $display("FAIL sync_timeout: rises=%0d required=%0d", second ? rises2 : rises, target);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ps = 1'b1; code = 5'h1f; clear = 1'b0;
        ps2 = 1'b0; code2 = 5'h00; clear2 = 1'b0; rd_addr = '0; rd_addr2 = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (sync !== 1'b0)  begin fails++; $display("FAIL reset_sync: got %b want 0", sync); end
        checks++; if (count !== 13'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (tape_v !== 5'd0) begin fails++; $display("FAIL reset_tape: got %h want 00", tape_v); end
        checks++; if (ovf !== 1'b0)   begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        ps = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_char;
        int base, req;
        code = 5'h13;
        wait_ticks(1);
        base = rises; req = tick_total;
        ps = 1'b1;
        wait_rises(1'b0, base + 1, 100 * TP);
        ps = 1'b0;
        checks++; if (rise_tick[base] - req !== 30) begin fails++;
            $display("FAIL first_sync_delay: got %0d ticks want 30", rise_tick[base] - req); end
        repeat (12) @(negedge clk); #1;
        checks++; if (width !== 8) begin fails++; $display("FAIL sync_width: got %0d want 8", width); end
        checks++; if (count !== 13'd1) begin fails++; $display("FAIL single_count: got %0d want 1", count); end
        rd_addr = 12'd0; #1;
        checks++; if (rd_data !== 5'h13) begin fails++; $display("FAIL single_buf0: got %h want 13", rd_data); end
        checks++; if (tape_v !== 5'h13) begin fails++; $display("FAIL single_tape: got %h want 13", tape_v); end
        repeat (70 * TP) @(negedge clk); #1;
        checks++; if (rises !== base + 1) begin fails++;
            $display("FAIL single_no_repeat: got %0d syncs want %0d", rises - base, 1); end
    endtask

    task automatic test_stream;
        int base;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        code = 5'h01;
        wait_ticks(1);
        base = rises;
        ps = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_rises(1'b0, base + i + 1, 100 * TP);
            if (i == 15) ps = 1'b0;
            repeat (12) @(negedge clk); #1;
            code = 5'(i + 2);
        end
        for (int i = 1; i < 16; i++) begin
            checks++; if (rise_tick[base + i] - rise_tick[base + i - 1] !== 59) begin fails++;
                $display("FAIL stream_spacing[%0d]: got %0d ticks want 59", i,
                         rise_tick[base + i] - rise_tick[base + i - 1]); end
        end
        checks++; if (count !== 13'd16) begin fails++; $display("FAIL stream_count: got %0d want 16", count); end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 12'(i); #1;
            checks++; if (rd_data !== 5'(i + 1)) begin fails++;
                $display("FAIL stream_buf[%0d]: got %h want %h", i, rd_data, 5'(i + 1)); end
        end
    endtask

    task automatic test_abort_spinup;
        int base;
        repeat (60 * TP) @(negedge clk);
        wait_ticks(1);
        base = rises;
        ps = 1'b1;
        wait_ticks(5);
        ps = 1'b0;
        repeat (40 * TP) @(negedge clk); #1;
        checks++; if (rises !== base) begin fails++; $display("FAIL abort_sync: got %0d syncs want 0", rises - base); end
        checks++; if (count !== 13'd16) begin fails++; $display("FAIL abort_count: got %0d want 16", count); end
    endtask

    task automatic test_full;
        code2 = 5'h11;
        wait_ticks(1);
        ps2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_rises(1'b1, i + 1, 100 * TP);
            if (i == 5) ps2 = 1'b0;
            repeat (12) @(negedge clk); #1;
            code2 = 5'(8'h12 + i);
            if (i == 3) begin
                checks++; if (count2 !== 3'd4) begin fails++; $display("FAIL full_count4: got %0d want 4", count2); end
                checks++; if (ovf2 !== 1'b0) begin fails++; $display("FAIL full_ovf_early: got %b want 0", ovf2); end
            end
        end
        checks++; if (count2 !== 3'd4) begin fails++; $display("FAIL full_count_sat: got %0d want 4", count2); end
        checks++; if (ovf2 !== 1'b1) begin fails++; $display("FAIL full_ovf: got %b want 1", ovf2); end
        checks++; if (tape2_v !== 5'h16) begin fails++; $display("FAIL full_tape: got %h want 16", tape2_v); end
        for (int i = 0; i < 4; i++) begin
            rd_addr2 = 2'(i); #1;
            checks++; if (rd_data2 !== 5'(8'h11 + i)) begin fails++;
                $display("FAIL full_buf[%0d]: got %h want %h", i, rd_data2, 5'(8'h11 + i)); end
        end
        @(negedge clk); clear2 = 1'b1;
        @(negedge clk); clear2 = 1'b0;
        #1;
        checks++; if (count2 !== 3'd0) begin fails++; $display("FAIL clear_count: got %0d want 0", count2); end
        checks++; if (ovf2 !== 1'b0) begin fails++; $display("FAIL clear_ovf: got %b want 0", ovf2); end
        checks++; if (tape2_v !== 5'd0) begin fails++; $display("FAIL clear_tape: got %h want 00", tape2_v); end
    endtask

    task automatic test_mid_char_reset;
        int base, req;
        code = 5'h0a;
        wait_ticks(1);
        base = rises;
        ps = 1'b1;
        wait_rises(1'b0, base + 1, 100 * TP);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (sync !== 1'b0) begin fails++; $display("FAIL midreset_sync: got %b want 0", sync); end
        checks++; if (count !== 13'd0) begin fails++; $display("FAIL midreset_count: got %0d want 0", count); end
        repeat (3) @(negedge clk);
        wait_ticks(1);
        req = tick_total;
        rst_n = 1'b1;
        wait_rises(1'b0, base + 2, 100 * TP);
        checks++; if (rise_tick[(base + 1) & 63] - req !== 30) begin fails++;
            $display("FAIL midreset_respin: got %0d ticks want 30", rise_tick[(base + 1) & 63] - req); end
        ps = 1'b0;
        repeat (12) @(negedge clk); #1;
        checks++; if (count !== 13'd1) begin fails++; $display("FAIL midreset_newcount: got %0d want 1", count); end
        rd_addr = 12'd0; #1;
        checks++; if (rd_data !== 5'h0a) begin fails++; $display("FAIL midreset_buf0: got %h want 0a", rd_data); end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_stream();
        test_abort_spinup();
        test_full();
        test_mid_char_reset();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
